// File: rtl/neuron_clk_divider_pkg.sv
// neuron_clk_pkg: shared widths, defaults and tap offsets for the neuron clock divider
package neuron_clk_pkg;
    localparam int HALF_CNT_W      = 18;
    localparam int NN_DEFAULT      = 8;
    localparam int SIM_BIT_OFS     = 1;
    localparam int SPINDLE_BIT_OFS = 3;

    function automatic int cnt_w(input int nn);
        return nn + 3;
    endfunction
endpackage

// File: rtl/neuron_clk_divider_if.sv
// neuron_clk_divider_if: half-period control and generated clocks/counter
//   half_cnt           half period in rawclk cycles minus one (master -> slave)
//   clk_out1           neuron clock
//   clk_out2           sim clock (counter bit NN-1)
//   clk_out3           spindle clock (counter bit NN-3)
//   int_neuron_cnt_out neuron-cycle counter, NN+3 bits
interface neuron_clk_divider_if
    import neuron_clk_pkg::*;
#(
    parameter int NN = NN_DEFAULT
);
    logic [HALF_CNT_W-1:0] half_cnt;
    logic                  clk_out1;
    logic                  clk_out2;
    logic                  clk_out3;
    logic [cnt_w(NN)-1:0]  int_neuron_cnt_out;

    modport master (
        output half_cnt,
        input  clk_out1, clk_out2, clk_out3, int_neuron_cnt_out
    );

    modport slave (
        input  half_cnt,
        output clk_out1, clk_out2, clk_out3, int_neuron_cnt_out
    );
endinterface

// File: rtl/neuron_clk_divider_half_period_divider.sv
// half_period_divider: divides clk by 2*(half_cnt+1), 50% duty, with rise strobe
//   clk        input  rawclk domain clock
//   rst        input  asynchronous active-high reset
//   half_cnt_i input  half period in clk cycles minus one
//   clk_o      output divided clock, registered
//   rise_o     output high in the cycle whose clock edge takes clk_o 0->1
// Optional macro NEURON_CLK_DIVIDER_HALF_CNT_LATCH_EN: half_cnt_i is held in a
// shadow register reloaded on each toggle, so changes land on half-period
// boundaries only.
module half_period_divider
    import neuron_clk_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HALF_CNT_W-1:0] half_cnt_i,
    output logic                  clk_o,
    output logic                  rise_o
);
    logic [HALF_CNT_W-1:0] div_q, div_d, lim;
    logic                  clk_q, clk_d, tc;

`ifdef NEURON_CLK_DIVIDER_HALF_CNT_LATCH_EN
    logic [HALF_CNT_W-1:0] shadow_q, shadow_d;
    assign lim      = shadow_q;
    assign shadow_d = tc ? half_cnt_i : shadow_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_q <= half_cnt_i;
        else     shadow_q <= shadow_d;
    end
`else
    assign lim = half_cnt_i;
`endif

    // >= so a limit lowered below the running count terminates on the next edge
    assign tc     = div_q >= lim;
    assign div_d  = tc ? '0 : div_q + 1'b1;
    assign clk_d  = clk_q ^ tc;
    assign rise_o = tc & ~clk_q;
    assign clk_o  = clk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            clk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            clk_q <= clk_d;
        end
    end
endmodule

// File: rtl/neuron_clk_divider.sv
// neuron_clk_divider: neuron/sim/spindle clock generator with neuron-cycle counter
//   rawclk input  sole clock
//   reset  input  asynchronous active-high reset
//   bus    slave  half_cnt in; clk_out1..3 and int_neuron_cnt_out out
// Optional macro NEURON_CLK_DIVIDER_HALF_CNT_LATCH_EN (see half_period_divider).
module neuron_clk_divider
    import neuron_clk_pkg::*;
#(
    parameter int NN = NN_DEFAULT
)(
    input  logic                 rawclk,
    input  logic                 reset,
    neuron_clk_divider_if.slave  bus
);
    localparam int CW = cnt_w(NN);

    if (NN < 3) begin : g_nn_check
        $error("neuron_clk_divider: NN must be >= 3");
    end

    logic          rise;
    logic [CW-1:0] cnt_q, cnt_d;

    half_period_divider u_div (
        .clk        (rawclk),
        .rst        (reset),
        .half_cnt_i (bus.half_cnt),
        .clk_o      (bus.clk_out1),
        .rise_o     (rise)
    );

    // counter steps on the same edge clk_out1 rises; wraps silently
    assign cnt_d = rise ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge rawclk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bus.int_neuron_cnt_out = cnt_q;
    assign bus.clk_out2           = cnt_q[NN-SIM_BIT_OFS];
    assign bus.clk_out3           = cnt_q[NN-SPINDLE_BIT_OFS];
endmodule

// File: tb/tb_neuron_clk_divider.sv
// tb_neuron_clk_divider: scoreboard bench for neuron_clk_divider
module tb_neuron_clk_divider;
    localparam int NN = 8;
    localparam int CW = NN + 3;

    typedef struct {
        int            cyc;
        logic          lvl;
        logic [CW-1:0] cnt;
    } ev_t;

    logic  rawclk, reset;
    int    nchk, nerr, cyc;
    logic  mon_en, prev;
    ev_t   q[$];

    neuron_clk_divider_if #(.NN(NN)) bus ();
    neuron_clk_divider #(.NN(NN)) dut (.rawclk(rawclk), .reset(reset), .bus(bus));

    initial rawclk = 1'b0;
    always #5 rawclk = ~rawclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge rawclk) cyc <= reset ? 0 : cyc + 1;

    always @(negedge rawclk) begin
        if (mon_en && !reset) begin
            if (bus.clk_out1 !== prev) begin
                if (q.size() == 0) check("extra_edge", 1, 0);
                else begin
                    ev_t e;
                    e = q.pop_front();
                    check("edge_cyc", cyc, e.cyc);
                    check("clk_out1", bus.clk_out1, e.lvl);
                    check("cnt", bus.int_neuron_cnt_out, e.cnt);
                    check("clk_out2", bus.clk_out2, e.cnt[NN-1]);
                    check("clk_out3", bus.clk_out3, e.cnt[NN-3]);
                end
            end
            prev = bus.clk_out1;
        end
    end

    task automatic push_edge(input int c, input int j);
        ev_t e;
        int  k;
        k     = (j + 1) / 2;
        e.cyc = c;
        e.lvl = j[0];
        e.cnt = k[CW-1:0];
        q.push_back(e);
    endtask

    task automatic start(input int h);
        mon_en = 1'b0;
        reset  = 1'b1;
        bus.half_cnt = h[17:0];
        repeat (3) @(negedge rawclk);
        q.delete();
        prev   = 1'b0;
        mon_en = 1'b1;
        reset  = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(negedge rawclk);
            #1;
        end
        mon_en = 1'b0;
        check("drain_left", q.size(), 0);
    endtask

    task automatic run_const(input int h, input int nedges);
        start(h);
        for (int j = 1; j <= nedges; j++) push_edge(j * (h + 1), j);
        drain(nedges * (h + 1) + 50);
    endtask

    initial begin
        int base;
        nchk = 0; nerr = 0; mon_en = 1'b0; prev = 1'b0;
        reset = 1'b0;
        bus.half_cnt = 18'd197;
        #1 reset = 1'b1;
        repeat (20) @(negedge rawclk);
        check("rst_clk1", bus.clk_out1, 0);
        check("rst_clk2", bus.clk_out2, 0);
        check("rst_clk3", bus.clk_out3, 0);
        check("rst_cnt", bus.int_neuron_cnt_out, 0);

        run_const(197, 10);

        start(197);
        for (int i = 0; i < 1000 && bus.clk_out1 !== 1'b1; i++) @(negedge rawclk);
        check("await_high", bus.clk_out1, 1);
        mon_en = 1'b0;
        @(negedge rawclk);
        #1 reset = 1'b1;
        #1;
        check("async_clk1", bus.clk_out1, 0);
        check("async_cnt", bus.int_neuron_cnt_out, 0);

        run_const(0, 12);
        run_const(1, 4200);

        start(197);
        push_edge(198, 1);
`ifdef NEURON_CLK_DIVIDER_HALF_CNT_LATCH_EN
        base = 396;
`else
        base = 299;
`endif
        for (int j = 2; j <= 10; j++) push_edge(base + 4 * (j - 2), j);
        for (int i = 0; i < 400 && cyc != 298; i++) @(negedge rawclk);
        check("sync_298", cyc, 298);
        bus.half_cnt = 18'd3;
        drain(600);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
